boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, giving the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 6, giving the word-address width; DEPTH_WORDS <= 2^ADDR_W.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports are clk and rst.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 byte_in  input  8  serial program byte from the host link.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  output  32  assembled instruction word.
REQ-012 core_rst  output  1  holds the processor core in reset while high.
REQ-013 done  output  1  program loaded; core released.
REQ-014 err  output  1  image length rejected.

Function
REQ-015 SHALL transfer a byte only on a rising edge where byte_valid=1 and byte_ready=1; byte_valid while byte_ready=0 is ignored and not consumed.
REQ-016 SHALL implement states LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-017 LEN_LO: byte_ready=1; on transfer, latch N[7:0] and go to LEN_HI.
REQ-018 LEN_HI: byte_ready=1; on transfer, latch N[15:8]; if N=0 go to DONE; if N>DEPTH_WORDS go to ERR; otherwise go to DATA with byte index 0 and word address 0.
REQ-019 DATA: byte_ready=1; each transfer places the byte at position index*8 of the word buffer (little-endian; first byte is bits 7:0); the 4th transfer goes to WRITE.
REQ-020 WRITE: lasts exactly one cycle; imem_we=1, imem_wdata=assembled word, imem_addr=current word address, byte_ready=0.
REQ-021 After WRITE, the word address SHALL increment by 1; if the written word was word N-1, go to DONE; otherwise return to DATA with byte index 0.
REQ-022 imem_we SHALL be 0 in every state other than WRITE; imem_addr and imem_wdata are don't-care when imem_we=0 but SHALL be driven, never X.
REQ-023 DONE: core_rst=0, done=1, byte_ready=0; the state is terminal until rst.
REQ-024 ERR: core_rst=1, err=1, byte_ready=0, no memory writes; the state is terminal until rst.
REQ-025 core_rst SHALL be 1 in every state except DONE, and it SHALL fall in the same cycle done rises.
REQ-026 Minimum load time SHALL be 2 + 5N cycles from the first transfer to done=1 when byte_valid is held high.
REQ-027 The word address counter SHALL never exceed N-1 at a write and SHALL NOT wrap.
REQ-028 The byte index and word address SHALL only advance on transfers or WRITE; stalls (byte_valid=0) SHALL hold all state.

Reset
REQ-029 rst=1 SHALL immediately force state LEN_LO, N=0, byte index=0, word address=0, word buffer=0.
REQ-030 During and after reset, outputs SHALL be byte_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0.
REQ-031 rst asserted mid-load (any state, including WRITE or DONE) SHALL abort the load with no further imem_we pulse and re-assert core_rst asynchronously; a new load restarts from LEN_LO.

Verification
REQ-032 Stream 02 00 13 05 10 00 93 05 20 00 with byte_valid high -> imem_we at addr 0 data 0x00100513, then addr 1 data 0x00200593; done=1 and core_rst=0 on the cycle after the second write; total time 12 cycles.
REQ-033 Length bytes 00 00 -> DONE directly after LEN_HI; no imem_we pulse; done=1.
REQ-034 Length 41 00 (65 > 64) -> err=1, core_rst stays 1, byte_ready=0, no writes; further bytes are ignored.
REQ-035 Length 01 00, then data bytes with byte_valid toggling 1,0,0,1,... -> a single write of the correct little-endian word; no byte is lost or duplicated during stalls.
REQ-036 Assert rst during the WRITE cycle of word 3 of 5 -> imem_we drops at once; outputs match REQ-030; a fresh 1-word load afterwards writes addr 0.
REQ-037 Length 40 00 (64 = DEPTH_WORDS), full stream -> the last write is at addr 63, then done=1; the address counter does not wrap to 0.

Source files
------------

// File: rtl/boot_loader_if.sv
// Byte link from the host plus the instruction-memory write port and core-control outputs of the boot loader.
// The host drives the master side; the loader sits on the slave side.
interface boot_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );
endinterface

// File: rtl/boot_loader.sv
// Serial boot loader: reads a 16-bit little-endian word count and then the program bytes.
// It assembles 32-bit words, writes them to instruction memory, and releases the core when the load finishes.
module boot_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 6
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [15:0]       r_len;
  logic [1:0]        r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_buf;

  logic              w_ready;
  logic              w_xfer;
  logic              w_we;
  logic              w_coreRst;
  logic              w_done;
  logic              w_err;
  logic              w_lastWord;
  logic [15:0]       w_lenFull;

  assign w_xfer     = bus.byte_valid & w_ready;
  assign w_lenFull  = {bus.byte_in, r_len[7:0]};
  assign w_lastWord = (16'(r_addr) == (r_len - 16'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LEN_LO;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_we        = 1'b0;
    w_coreRst   = 1'b1;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      LEN_LO: begin
        w_ready = 1'b1;
        if (w_xfer) w_nextState = LEN_HI;
      end
      LEN_HI: begin
        w_ready = 1'b1;
        if (w_xfer) begin
          if (w_lenFull == 16'd0) begin
            w_nextState = DONE;
          end else if (w_lenFull > 16'(DEPTH_WORDS)) begin
            w_nextState = ERR;
          end else begin
            w_nextState = DATA;
          end
        end
      end
      DATA: begin
        w_ready = 1'b1;
        if (w_xfer && (r_idx == 2'd3)) w_nextState = WRITE;
      end
      WRITE: begin
        w_we        = 1'b1;
        w_nextState = w_lastWord ? DONE : DATA;
      end
      DONE: begin
        w_coreRst = 1'b0;
        w_done    = 1'b1;
      end
      ERR: begin
        w_err = 1'b1;
      end
      default: begin
        w_nextState = LEN_LO;
      end
    endcase
  end

  // The address holds on the final word so it never wraps past the image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= 16'd0;
      r_idx  <= 2'd0;
      r_addr <= '0;
      r_buf  <= 32'd0;
    end else begin
      case (r_state)
        LEN_LO: begin
          if (w_xfer) r_len[7:0] <= bus.byte_in;
        end
        LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= bus.byte_in;
            r_idx       <= 2'd0;
            r_addr      <= '0;
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_buf[{r_idx, 3'b000} +: 8] <= bus.byte_in;
            r_idx                       <= r_idx + 2'd1;
          end
        end
        WRITE: begin
          r_idx <= 2'd0;
          if (!w_lastWord) r_addr <= r_addr + ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.imem_we    = w_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_buf;
  assign bus.core_rst   = w_coreRst;
  assign bus.done       = w_done;
  assign bus.err        = w_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader: normal loads, empty and oversized images, stalls, mid-load reset and a full-depth image.
module tb_boot_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  boot_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int passCount  = 0;
  int totalCount = 0;
  int cycleCnt   = 0;
  int wrCount    = 0;
  int wrBase     = 0;
  int startCycle = 0;
  logic [ADDR_W-1:0] wrAddr [0:255];
  logic [31:0]       wrData [0:255];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Every write strobe seen between clock edges is logged for later checks.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wrCount < 256) begin
        wrAddr[wrCount] = bus.imem_addr;
        wrData[wrCount] = bus.imem_wdata;
      end
      wrCount = wrCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount = totalCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Presents one byte and holds it until the loader accepts it on an edge.
  task automatic applyStimulus(input logic [7:0] b);
    logic acc;
    acc            = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int n = 0; n < 10 && !acc; n++) begin
      acc = bus.byte_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      totalCount = totalCount + 1;
      $error("[TB] FAIL send_timeout: byte 0x%02h observed not accepted expected accepted", b);
    end
  endtask

  task automatic checkResetOutputs(input string pre);
    checkOutput({pre, "_ready"},  32'(bus.byte_ready), 32'd1);
    checkOutput({pre, "_we"},     32'(bus.imem_we),    32'd0);
    checkOutput({pre, "_addr"},   32'(bus.imem_addr),  32'd0);
    checkOutput({pre, "_wdata"},  bus.imem_wdata,      32'd0);
    checkOutput({pre, "_coreRst"},32'(bus.core_rst),   32'd1);
    checkOutput({pre, "_done"},   32'(bus.done),       32'd0);
    checkOutput({pre, "_err"},    32'(bus.err),        32'd0);
  endtask

  task automatic resetPulse();
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] stream [0:9];
    logic [7:0] dataBytes [0:3];
    int badSeq;

    // Reset values while held and just after release.
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkResetOutputs("postRst");

    // Two-word program with byte_valid held high.
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    wrBase     = wrCount;
    startCycle = cycleCnt;
    for (int i = 0; i < 10; i++) applyStimulus(stream[i]);
    checkOutput("t1_secondWe",    32'(bus.imem_we),   32'd1);
    checkOutput("t1_secondAddr",  32'(bus.imem_addr), 32'd1);
    checkOutput("t1_doneEarly",   32'(bus.done),      32'd0);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    checkOutput("t1_done",        32'(bus.done),      32'd1);
    checkOutput("t1_coreRst",     32'(bus.core_rst),  32'd0);
    checkOutput("t1_ready",       32'(bus.byte_ready),32'd0);
    checkOutput("t1_cycles",      32'(cycleCnt - startCycle), 32'd12);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t1_wrCount",     32'(wrCount - wrBase), 32'd2);
    checkOutput("t1_addr0",       32'(wrAddr[wrBase]),     32'd0);
    checkOutput("t1_data0",       wrData[wrBase],          32'h00100513);
    checkOutput("t1_addr1",       32'(wrAddr[wrBase + 1]), 32'd1);
    checkOutput("t1_data1",       wrData[wrBase + 1],      32'h00200593);

    // Zero-length image goes straight to done.
    resetPulse();
    wrBase = wrCount;
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    bus.byte_valid = 1'b0;
    checkOutput("t2_done",    32'(bus.done),       32'd1);
    checkOutput("t2_coreRst", 32'(bus.core_rst),   32'd0);
    checkOutput("t2_ready",   32'(bus.byte_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("t2_wrCount", 32'(wrCount - wrBase), 32'd0);

    // Oversized image (65 words) is rejected and later bytes are ignored.
    resetPulse();
    wrBase = wrCount;
    applyStimulus(8'h41);
    applyStimulus(8'h00);
    checkOutput("t3_err",     32'(bus.err),        32'd1);
    checkOutput("t3_coreRst", 32'(bus.core_rst),   32'd1);
    checkOutput("t3_ready",   32'(bus.byte_ready), 32'd0);
    checkOutput("t3_done",    32'(bus.done),       32'd0);
    bus.byte_in    = 8'h12;
    bus.byte_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    checkOutput("t3_errHeld", 32'(bus.err),          32'd1);
    checkOutput("t3_wrCount", 32'(wrCount - wrBase), 32'd0);

    // One word delivered with two idle cycles after every byte.
    resetPulse();
    wrBase = wrCount;
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    dataBytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(dataBytes[i]);
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'hA5;
      repeat (2) @(posedge clk);
      #1;
    end
    checkOutput("t4_wrCount", 32'(wrCount - wrBase), 32'd1);
    checkOutput("t4_addr",    32'(wrAddr[wrBase]),   32'd0);
    checkOutput("t4_data",    wrData[wrBase],        32'hDEADBEEF);
    checkOutput("t4_done",    32'(bus.done),         32'd1);

    // Reset during the write of the third word of five, then a fresh one-word load.
    resetPulse();
    wrBase = wrCount;
    applyStimulus(8'h05);
    applyStimulus(8'h00);
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) applyStimulus(8'(w * 16 + k));
    end
    checkOutput("t5_weBefore",   32'(bus.imem_we),   32'd1);
    checkOutput("t5_addrBefore", 32'(bus.imem_addr), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    checkResetOutputs("t5_abort");
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.byte_valid = 1'b0;
    checkOutput("t5_wrCountAbort", 32'(wrCount - wrBase), 32'd2);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    bus.byte_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_wrCountNew", 32'(wrCount - wrBase),     32'd3);
    checkOutput("t5_newAddr",    32'(wrAddr[wrBase + 2]),   32'd0);
    checkOutput("t5_newData",    wrData[wrBase + 2],        32'h44332211);
    checkOutput("t5_newDone",    32'(bus.done),             32'd1);

    // Full-depth image of 64 words.
    resetPulse();
    wrBase = wrCount;
    applyStimulus(8'h40);
    applyStimulus(8'h00);
    for (int i = 0; i < 256; i++) applyStimulus(8'(i));
    checkOutput("t6_lastWe",   32'(bus.imem_we),   32'd1);
    checkOutput("t6_lastAddr", 32'(bus.imem_addr), 32'd63);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    checkOutput("t6_done",     32'(bus.done),           32'd1);
    checkOutput("t6_wrCount",  32'(wrCount - wrBase),   32'd64);
    badSeq = 0;
    for (int w = 0; w < 64; w++) begin
      if (wrAddr[wrBase + w] !== ADDR_W'(w)) badSeq = badSeq + 1;
    end
    checkOutput("t6_addrSeq",  32'(badSeq),             32'd0);
    checkOutput("t6_firstData",wrData[wrBase],          32'h03020100);
    checkOutput("t6_lastData", wrData[wrBase + 63],     32'hFFFEFDFC);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_noExtraWr",32'(wrCount - wrBase),   32'd64);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
